// File: rtl/moore_run_detector.sv
// Moore run-length detector: z is high while the last RUN_LEN enabled samples equal Pol.
// Supports sticky (Mode=0) and re-arming (Mode=1) detection plus a saturating event counter.
module moore_run_detector #(
    parameter int RUN_LEN = 2,
    parameter int CNT_W   = 8,
    localparam int SW     = $clog2(RUN_LEN + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic             Clear,
    input  logic             w,
    input  logic             Pol,
    input  logic             Mode,
    output logic             z,
    output logic [SW-1:0]    y,
    output logic [CNT_W-1:0] det_count,
    output logic             sat
);

    localparam logic [SW-1:0]    LP_ZERO      = SW'(0);
    localparam logic [SW-1:0]    LP_ONE       = SW'(1);
    localparam logic [SW-1:0]    LP_FULL      = SW'(RUN_LEN);
    localparam logic [SW-1:0]    LP_LAST      = SW'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX   = {CNT_W{1'b1}};
    // With a one-sample run, the re-arm path S1->S1 is the only way to re-enter the full state.
    localparam logic             LP_REARM_EVT = (RUN_LEN == 1) ? 1'b1 : 1'b0;

    logic [SW-1:0]    r_y;
    logic             r_z;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    logic [SW-1:0]    w_next;
    logic             w_event;
    logic             w_match;
    logic             w_illegal;

    // Next run count and detection-event decode for the current sample.
    always_comb begin
        w_match   = (w == Pol);
        w_illegal = (int'(r_y) > RUN_LEN);
        w_next    = r_y;
        w_event   = 1'b0;
        if (w_illegal) begin
            w_next = LP_ZERO;
        end else if (!En) begin
            w_next = r_y;
        end else if (!w_match) begin
            w_next = LP_ZERO;
        end else if (r_y != LP_FULL) begin
            w_next  = r_y + LP_ONE;
            w_event = (r_y == LP_LAST);
        end else if (Mode) begin
            w_next  = LP_ONE;
            w_event = LP_REARM_EVT;
        end else begin
            w_next = r_y;
        end
    end

    // State, registered detect output and saturating event counter; Clear outranks En.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_y   <= LP_ZERO;
            r_z   <= 1'b0;
            r_cnt <= {CNT_W{1'b0}};
            r_sat <= 1'b0;
        end else if (Clear) begin
            r_y   <= LP_ZERO;
            r_z   <= 1'b0;
            r_cnt <= {CNT_W{1'b0}};
            r_sat <= 1'b0;
        end else begin
            r_y <= w_next;
            r_z <= (w_next == LP_FULL);
            if (w_event) begin
                if (r_cnt == LP_CNT_MAX) begin
                    r_sat <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + LP_CNT_ONE;
                end
            end
        end
    end

    assign y         = r_y;
    assign z         = r_z;
    assign det_count = r_cnt;
    assign sat       = r_sat;

endmodule

// File: tb/tb_moore_run_detector.sv
// Scoreboard bench for moore_run_detector: three configurations share one stimulus stream,
// a run-length reference model queues expectations and a negedge monitor compares them.
module tb_moore_run_detector;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic En = 1'b0, Clear = 1'b0, w = 1'b0, Pol = 1'b1, Mode = 1'b0;

    logic       z2, z3, z1;
    logic [1:0] y2, y3;
    logic [0:0] y1;
    logic [7:0] c2;
    logic [3:0] c3;
    logic [1:0] c1;
    logic       s2, s3, s1;

    always #5 Clock = ~Clock;

    moore_run_detector #(.RUN_LEN(2), .CNT_W(8)) u_d2 (
        .Clock(Clock), .Reset(Reset), .En(En), .Clear(Clear), .w(w), .Pol(Pol), .Mode(Mode),
        .z(z2), .y(y2), .det_count(c2), .sat(s2));
    moore_run_detector #(.RUN_LEN(3), .CNT_W(4)) u_d3 (
        .Clock(Clock), .Reset(Reset), .En(En), .Clear(Clear), .w(w), .Pol(Pol), .Mode(Mode),
        .z(z3), .y(y3), .det_count(c3), .sat(s3));
    moore_run_detector #(.RUN_LEN(1), .CNT_W(2)) u_d1 (
        .Clock(Clock), .Reset(Reset), .En(En), .Clear(Clear), .w(w), .Pol(Pol), .Mode(Mode),
        .z(z1), .y(y1), .det_count(c1), .sat(s1));

    typedef struct {
        int y[3];
        int c[3];
        int s[3];
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model: run length, event count and saturation flag per configuration.
    int ml[3]  = '{2, 3, 1};
    int mcw[3] = '{8, 4, 2};
    int m_y[3] = '{0, 0, 0};
    int m_c[3] = '{0, 0, 0};
    int m_s[3] = '{0, 0, 0};

    task automatic cmp(input string nm, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_y[d] = 0; m_c[d] = 0; m_s[d] = 0;
        end
    endfunction

    function automatic void model_step(input logic en, input logic clr, input logic wi,
                                       input logic pol, input logic mode);
        for (int d = 0; d < 3; d++) begin
            int  prev;
            bit  evt;
            if (clr) begin
                m_y[d] = 0; m_c[d] = 0; m_s[d] = 0;
            end else if (en) begin
                prev = m_y[d];
                if (wi != pol)           m_y[d] = 0;
                else if (prev < ml[d])   m_y[d] = prev + 1;
                else if (mode)           m_y[d] = 1;
                else                     m_y[d] = ml[d];
                evt = (wi == pol) && (m_y[d] == ml[d]) && ((prev != ml[d]) || (ml[d] == 1 && mode));
                if (evt) begin
                    if (m_c[d] == (1 << mcw[d]) - 1) m_s[d] = 1;
                    else                             m_c[d] = m_c[d] + 1;
                end
            end
        end
    endfunction

    task automatic step(input logic en, input logic clr, input logic wi,
                        input logic pol, input logic mode);
        exp_t e;
        @(negedge Clock);
        En = en; Clear = clr; w = wi; Pol = pol; Mode = mode;
        model_step(en, clr, wi, pol, mode);
        e.y = m_y; e.c = m_c; e.s = m_s;
        @(posedge Clock);
        #1;
        sb_q.push_back(e);
    endtask

    // Monitor: every queued expectation is compared against all three DUTs on the falling edge.
    always @(negedge Clock) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp("d2_y", int'(y2), e.y[0]);
            cmp("d2_z", int'(z2), int'(e.y[0] == 2));
            cmp("d2_cnt", int'(c2), e.c[0]);
            cmp("d2_sat", int'(s2), e.s[0]);
            cmp("d3_y", int'(y3), e.y[1]);
            cmp("d3_z", int'(z3), int'(e.y[1] == 3));
            cmp("d3_cnt", int'(c3), e.c[1]);
            cmp("d3_sat", int'(s3), e.s[1]);
            cmp("d1_y", int'(y1), e.y[2]);
            cmp("d1_z", int'(z1), int'(e.y[2] == 1));
            cmp("d1_cnt", int'(c1), e.c[2]);
            cmp("d1_sat", int'(s1), e.s[2]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rp, rm, rw, ren, rclr;
        #3;
        cmp("rst_y2", int'(y2), 0);
        cmp("rst_z2", int'(z2), 0);
        cmp("rst_c2", int'(c2), 0);
        cmp("rst_s2", int'(s2), 0);
        #4 Reset = 1'b0;
        model_reset();

        // Sticky mode, ones: w=0,1,1,1,0
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cmp("seq1_z2_after3", int'(z2), 1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cmp("seq1_cnt2", int'(c2), 1);
        cmp("seq1_y2", int'(y2), 0);

        // Re-arm mode, seven continuous ones
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        cmp("seq2_cnt3", int'(c3), 2);
        cmp("seq2_y3", int'(y3), 1);
        cmp("seq2_cnt1_sat", int'(c1), 3);
        cmp("seq2_sat1", int'(s1), 1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cmp("seq2_clr_sat1", int'(s1), 0);

        // Zero polarity: w=0,0,1,0,0 then Pol flips to 1 with w=0
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("seq3_cnt2", int'(c2), 2);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cmp("seq3_polflip_y2", int'(y2), 0);

        // Enable gating: w=1, three disabled zeros, w=1
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cmp("seq4_hold_y2", int'(y2), 1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cmp("seq4_z2", int'(z2), 1);
        cmp("seq4_cnt2", int'(c2), 1);

        // Clear on the same edge as a completing sample
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cmp("clr_win_y2", int'(y2), 0);
        cmp("clr_win_cnt2", int'(c2), 0);

        // Async reset between edges while the run is complete
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cmp("pre_rst_z2", int'(z2), 1);
        En = 1'b0; Clear = 1'b0;
        #2 Reset = 1'b1;
        #1;
        cmp("async_rst_y2", int'(y2), 0);
        cmp("async_rst_z2", int'(z2), 0);
        cmp("async_rst_cnt2", int'(c2), 0);
        model_reset();
        sb_q.delete();
        #1 Reset = 1'b0;

        // Randomised traffic, biased toward the active polarity to build runs
        rp = 1'b1; rm = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0)  rp = ~rp;
            if ($urandom_range(0, 14) == 0) rm = ~rm;
            ren  = ($urandom_range(0, 3) != 0);
            rclr = ($urandom_range(0, 39) == 0);
            rw   = ($urandom_range(0, 3) != 0) ? rp : ~rp;
            step(ren, rclr, rw, rp, rm);
        end

        @(negedge Clock);
        @(negedge Clock);
        cmp("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
